// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if
//   Bundle of the serial sample input and the published-frame outputs of the
//   TDM 1:8 demultiplexer.
//   master : serial source side (drives din/din_valid/frame_sync, observes results)
//   slave  : demultiplexer side (consumes samples, drives frame/status outputs)
//   Signals:
//     din         WIDTH     serial sample for current slot
//     din_valid   1         din carries a sample this cycle
//     frame_sync  1         marks din as channel 0 (qualified by din_valid)
//     frame_out   8*WIDTH   published frame, ch n at [n*WIDTH +: WIDTH]
//     frame_valid 1         one-cycle pulse when frame_out updates
//     slot        3 (4)     channel index the next valid sample is written to
//     locked      1         receiver is locked to the frame
//     sync_err    1         one-cycle pulse on framing error
//     parity_err  1         only with TDM_DEMUX_PARITY_EN: parity slot mismatch
//   Optional feature macro: TDM_DEMUX_PARITY_EN (adds the parity slot and parity_err).
interface tdm_demux8_if #(
  parameter int WIDTH = 1
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_W = 4;
`else
  localparam int SLOT_W = 3;
`endif

  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_sync;
  logic [8*WIDTH-1:0] frame_out;
  logic               frame_valid;
  logic [SLOT_W-1:0]  slot;
  logic               locked;
  logic               sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic               parity_err;

  modport master (
    output din, din_valid, frame_sync,
    input  frame_out, frame_valid, slot, locked, sync_err, parity_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output frame_out, frame_valid, slot, locked, sync_err, parity_err
  );
`else
  modport master (
    output din, din_valid, frame_sync,
    input  frame_out, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output frame_out, frame_valid, slot, locked, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8
//   Time-division 1-to-8 demultiplexer (receive end of the 8:1 channel mux).
//   Locks to frame_sync, steers each valid serial sample into its channel of a
//   shadow buffer and publishes all eight channels at once as a registered frame.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (released synchronously upstream)
//     bus    tdm_demux8_if.slave: din/din_valid/frame_sync in;
//            frame_out/frame_valid/slot/locked/sync_err (/parity_err) out
//   Parameter WIDTH: bits per channel sample (1..16); must match the interface.
//   Optional feature macro: TDM_DEMUX_PARITY_EN -- frames carry a ninth slot
//   holding the bitwise XOR of ch0..ch7; the frame completes on that slot and
//   parity_err reports a mismatch alongside frame_valid.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int                SLOT_W    = 4;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 4'd8;
  localparam bit                HAS_PAR   = 1'b1;
`else
  localparam int                SLOT_W    = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;
  localparam bit                HAS_PAR   = 1'b0;
`endif

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [SLOT_W-1:0]  slot_p0, slot_nxt;
  logic [WIDTH-1:0]   shadow_p0 [8];
  logic               wr_en;
  logic [2:0]         wr_idx;
  logic               complete;
  logic               err;
  logic [8*WIDTH-1:0] frame_nxt;

  logic [8*WIDTH-1:0] frame_out_p1;
  logic               frame_valid_p1;
  logic               sync_err_p1;

`ifdef TDM_DEMUX_PARITY_EN
  logic               parity_err_p1;

  // Even-parity reduction: bitwise XOR of all eight channels.
  function automatic logic [WIDTH-1:0] frame_parity(input logic [8*WIDTH-1:0] f);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int n = 0; n < 8; n++) begin
      p = p ^ f[n*WIDTH +: WIDTH];
    end
    return p;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      slot_p0 <= '0;
    end else begin
      state   <= state_nxt;
      slot_p0 <= slot_nxt;
    end
  end

  // Next-state and slot steering; nothing moves unless din_valid is high.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_p0;
    wr_en     = 1'b0;
    wr_idx    = slot_p0[2:0];
    complete  = 1'b0;
    err       = 1'b0;
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            state_nxt = LOCKED;
            slot_nxt  = SLOT_W'(1);
            wr_en     = 1'b1;
            wr_idx    = 3'd0;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // A sync mid-frame drops the partial frame and restarts on ch0.
            err      = (slot_p0 != '0);
            slot_nxt = SLOT_W'(1);
            wr_en    = 1'b1;
            wr_idx   = 3'd0;
          end else if (slot_p0 == '0) begin
            // Frame start without sync: framing lost, sample discarded.
            state_nxt = HUNT;
            err       = 1'b1;
          end else begin
            // The parity slot is not a channel, so it never lands in the shadow.
            wr_en    = !(HAS_PAR && (slot_p0 == LAST_SLOT));
            complete = (slot_p0 == LAST_SLOT);
            slot_nxt = complete ? '0 : slot_p0 + 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Frame image to publish; without parity the ch7 sample bypasses the shadow.
  always_comb begin
    frame_nxt = '0;
    for (int n = 0; n < 8; n++) begin
      frame_nxt[n*WIDTH +: WIDTH] = shadow_p0[n];
    end
`ifndef TDM_DEMUX_PARITY_EN
    frame_nxt[7*WIDTH +: WIDTH] = bus.din;
`endif
  end

  // Stage p0 -> p1: shadow capture and frame publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) begin
        shadow_p0[n] <= '0;
      end
      frame_out_p1   <= '0;
      frame_valid_p1 <= 1'b0;
      sync_err_p1    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_p1  <= 1'b0;
`endif
    end else begin
      frame_valid_p1 <= complete;
      sync_err_p1    <= err;
      if (wr_en) begin
        shadow_p0[wr_idx] <= bus.din;
      end
      if (complete) begin
        frame_out_p1  <= frame_nxt;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_p1 <= (frame_parity(frame_nxt) != bus.din);
`endif
      end
`ifdef TDM_DEMUX_PARITY_EN
      else if (frame_valid_p1) begin
        parity_err_p1 <= 1'b0;
      end
`endif
    end
  end

  assign bus.frame_out   = frame_out_p1;
  assign bus.frame_valid = frame_valid_p1;
  assign bus.slot        = slot_p0;
  assign bus.locked      = (state == LOCKED);
  assign bus.sync_err    = sync_err_p1;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err  = parity_err_p1;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8
//   Directed bench for tdm_demux8 with a frame scoreboard: every complete frame
//   sent pushes its expected contents; a negedge monitor pops one entry per
//   frame_valid pulse. Builds with WIDTH=1 by default, WIDTH=4 when
//   TDM_DEMUX_PARITY_EN is defined (frames then carry a parity slot).
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int WIDTH = 4;
  localparam logic [31:0] T1 = 32'h7654_3210;
  localparam logic [31:0] FA = 32'h9ABC_DEF1;
  localparam logic [31:0] FB = 32'h1357_2468;
  localparam logic [31:0] FC = 32'hC0FF_EE15;
`else
  localparam int WIDTH = 1;
  localparam logic [7:0] T1 = 8'h4D;
  localparam logic [7:0] FA = 8'hA6;
  localparam logic [7:0] FB = 8'h3C;
  localparam logic [7:0] FC = 8'h5A;
`endif
  localparam int FW = 8*WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux8_if #(.WIDTH(WIDTH)) bus();
  tdm_demux8 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [FW-1:0] frame;
    logic          perr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sync_err) se_cnt++;
      if (bus.frame_valid) begin
        fv_cnt++;
        chk("fv_se_exclusive", 64'(bus.sync_err), 64'd0);
        if (sb.size() == 0) begin
          chk("frame_expected", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_frame", 64'(bus.frame_out), 64'(mon_e.frame));
`ifdef TDM_DEMUX_PARITY_EN
          chk("sb_parity_err", 64'(bus.parity_err), 64'(mon_e.perr));
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic sync, input logic [WIDTH-1:0] d);
    bus.din_valid  = 1'b1;
    bus.frame_sync = sync;
    bus.din        = d;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  function automatic logic [WIDTH-1:0] par_of(input logic [FW-1:0] f);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int n = 0; n < 8; n++) p = p ^ f[n*WIDTH +: WIDTH];
    return p;
  endfunction
`endif

  // Sends channels first..7 (ch0 carries sync when first==0), then the parity slot if built in.
  task automatic send_tail(input logic [FW-1:0] fr, input int first, input int gap_at,
                           input int gap_len, input logic bad_par);
    for (int n = first; n < 8; n++) begin
      if (n == gap_at) idle(gap_len);
      send(n == 0, fr[n*WIDTH +: WIDTH]);
    end
`ifdef TDM_DEMUX_PARITY_EN
    send(1'b0, par_of(fr) ^ WIDTH'(bad_par));
`endif
  endtask

  task automatic send_frame(input logic [FW-1:0] fr, input int gap_at, input int gap_len,
                            input logic bad_par);
    exp_t e;
    e.frame = fr;
    e.perr  = bad_par;
    sb.push_back(e);
    send_tail(fr, 0, gap_at, gap_len, bad_par);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  int fv0, se0;

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame_out", 64'(bus.frame_out), 64'd0);
    chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_slot", 64'(bus.slot), 64'd0);
    chk("rst_locked", 64'(bus.locked), 64'd0);
    chk("rst_sync_err", 64'(bus.sync_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: single back-to-back frame from HUNT
    send_frame(T1, -1, 0, 1'b0);
    @(negedge clk);
    chk("t1_frame_valid", 64'(bus.frame_valid), 64'd1);
    chk("t1_frame_out", 64'(bus.frame_out), 64'(T1));
    chk("t1_slot", 64'(bus.slot), 64'd0);
    chk("t1_locked", 64'(bus.locked), 64'd1);
    @(negedge clk);
    chk("t1_fv_one_cycle", 64'(bus.frame_valid), 64'd0);

    // Test 2: two frames with a 3-cycle gap mid-frame
    fv0 = fv_cnt;
    se0 = se_cnt;
    send_frame(FA, 3, 3, 1'b0);
    send_frame(FB, 5, 3, 1'b0);
    drain("t2_drain");
    chk("t2_fv_pulses", 64'(fv_cnt - fv0), 64'd2);
    chk("t2_no_sync_err", 64'(se_cnt - se0), 64'd0);

    // Test 3: frame_sync arriving at slot 5
    fv0 = fv_cnt;
    se0 = se_cnt;
    send(1'b1, '1);
    for (int n = 1; n < 5; n++) send(1'b0, WIDTH'(n));
    @(negedge clk);
    chk("t3_slot5", 64'(bus.slot), 64'd5);
    begin
      exp_t e;
      e.frame = FC;
      e.perr  = 1'b0;
      sb.push_back(e);
    end
    send(1'b1, FC[WIDTH-1:0]);
    @(negedge clk);
    chk("t3_sync_err", 64'(bus.sync_err), 64'd1);
    chk("t3_slot1", 64'(bus.slot), 64'd1);
    chk("t3_no_fv", 64'(bus.frame_valid), 64'd0);
    chk("t3_locked", 64'(bus.locked), 64'd1);
    send(1'b0, FC[1*WIDTH +: WIDTH]);
    @(negedge clk);
    chk("t3_sync_err_pulse", 64'(bus.sync_err), 64'd0);
    send_tail(FC, 2, -1, 0, 1'b0);
    drain("t3_drain");
    chk("t3_fv_pulses", 64'(fv_cnt - fv0), 64'd1);
    chk("t3_sync_err_cnt", 64'(se_cnt - se0), 64'd1);

    // Frame start without sync while locked: back to HUNT with an error pulse
    send(1'b0, '1);
    @(negedge clk);
    chk("t7_sync_err", 64'(bus.sync_err), 64'd1);
    chk("t7_unlocked", 64'(bus.locked), 64'd0);
    chk("t7_frame_held", 64'(bus.frame_out), 64'(FC));

    // Test 5: asynchronous reset mid-frame at slot 4
    send(1'b1, '1);
    for (int n = 1; n < 4; n++) send(1'b0, '1);
    @(negedge clk);
    chk("t5_slot4", 64'(bus.slot), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_frame_out", 64'(bus.frame_out), 64'd0);
    chk("t5_rst_slot", 64'(bus.slot), 64'd0);
    chk("t5_rst_locked", 64'(bus.locked), 64'd0);
    chk("t5_rst_fv", 64'(bus.frame_valid), 64'd0);
    chk("t5_rst_se", 64'(bus.sync_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_hunt", 64'(bus.locked), 64'd0);

    // Test 4: 20 unsynchronised samples in HUNT are ignored
    fv0 = fv_cnt;
    se0 = se_cnt;
    for (int n = 0; n < 20; n++) send(1'b0, WIDTH'($urandom));
    @(negedge clk);
    chk("t4_locked", 64'(bus.locked), 64'd0);
    chk("t4_frame_out", 64'(bus.frame_out), 64'd0);
    chk("t4_slot", 64'(bus.slot), 64'd0);
    chk("t4_no_fv", 64'(fv_cnt - fv0), 64'd0);
    chk("t4_no_se", 64'(se_cnt - se0), 64'd0);

    // Relock after reset and deliver a frame
    send_frame(FB, 2, 1, 1'b0);
    drain("relock_drain");

`ifdef TDM_DEMUX_PARITY_EN
    // Test 6: correct and corrupted parity slot
    send_frame(T1, -1, 0, 1'b0);
    @(negedge clk);
    chk("t6_fv_good", 64'(bus.frame_valid), 64'd1);
    chk("t6_parity_ok", 64'(bus.parity_err), 64'd0);
    send_frame(T1, -1, 0, 1'b1);
    @(negedge clk);
    chk("t6_fv_bad", 64'(bus.frame_valid), 64'd1);
    chk("t6_parity_err", 64'(bus.parity_err), 64'd1);
    chk("t6_frame_published", 64'(bus.frame_out), 64'(T1));
    drain("t6_drain");
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
